shared_adder_mul_seq: RTL and testbench
=======================================

// Module: shared_adder_mul_seq
// PURPOSE
//  Multi-cycle RV32M multiply sequencer (MUL/MULH/MULHSU/MULHU), driving one external N-bit ripple-carry
//  adder (N-bit sum + carry-out) instead of owning a multiplier array. Sits beside the EX stage: EX
//  raises start, stalls on busy, takes result on done. Radix-2 shift-add on operand magnitudes, with
//  adder-based two's-complement fixups. Adder lives in the parent; this block only sequences it.
// PARAMETERS
//  N       32   operand/result width; the shared adder is N bits wide with carry-out
//  CNT_W   6    iteration-counter width, >= clog2(N)+1
// PORTS
//  clk      in   1    system clock; all state updates on rising edge
//  rst_n    in   1    asynchronous, active-low reset
//  start    in   1    request; sampled only in IDLE
//  op       in   2    00 MUL(low), 01 MULH(s*s), 10 MULHSU(s*u), 11 MULHU(u*u)
//  rs1      in   N    multiplicand, sampled with start
//  rs2      in   N    multiplier, sampled with start
//  flush    in   1    synchronous abort (pipeline flush)
//  busy     out  1    high in every non-IDLE state
//  done     out  1    one-cycle pulse, result valid
//  result   out  N    op==00 ? low word : high word; held until the next done
//  add_a    out  N    shared adder operand A
//  add_b    out  N    shared adder operand B
//  add_cin  out  1    shared adder carry-in
//  add_sum  in   N+1  shared adder {cout,sum}, combinational from add_a/add_b/add_cin
// BEHAVIOUR
//  Reset: state=IDLE; busy, done, result, add_a, add_b, add_cin, internal A/HI/LO/cnt all 0.
//  Flow: IDLE->[NEG_A]->[NEG_B]->ITER(xN)->[NEG_LO->NEG_HI]->DONE->IDLE. Bracketed states are skipped
//  when not needed. On start in IDLE, latch op and A=rs1, LO=rs2, HI=0, cnt=N-1.
//  sa=rs1[N-1]&(op==01|op==10). sb=rs2[N-1]&(op==01). nr=sa^sb.
//  NEG_A: add_a=~A, add_b=0, cin=1; A<=sum[N-1:0]. NEG_B: same on LO.
//  Magnitudes are treated as unsigned; 0x8000_0000 negates to itself, which is correct.
//  ITER: add_a=HI, add_b=LO[0]?A:0, cin=0; {HI,LO}<={add_sum[N:0],LO[N-1:1]}.
//    cnt decrements each cycle; leave ITER after the cycle with cnt==0.
//  NEG_LO: add_a=~LO, b=0, cin=1; LO<=sum, c<=add_sum[N].
//  NEG_HI: add_a=~HI, b=0, cin=c; HI<=sum.
//  DONE: done=1 for one cycle, result<=sel(HI,LO), then IDLE. Back-to-back start in the next cycle is legal.
//  Latency: start sampled in cycle 0 -> done in cycle N+1+sa+sb+2*nr. busy is high in cycles 1..done.
//  Outside NEG_*/ITER: add_a=0, add_b=0, add_cin=0, so the parent may mux the adder to other users.
//  start while busy: ignored, no queueing.
//  flush: any state -> IDLE next cycle, no done, result unchanged. Beats start in the same cycle.
//  rst_n low mid-operation: immediate return to reset values; in-flight result discarded.
//  op==00 ignores signs (sa=sb=0): the low word is sign-agnostic.
// STRUCTURE
//  mul_pkg: op encodings (OP_MUL..OP_MULHU) and state localparams/enum.
//  Single FSM plus datapath registers. No sub-module; the nbitRCA instance lives in the parent.
// TESTING (N=32)
//  MULHU 0xFFFFFFFF*0xFFFFFFFF -> result 0xFFFFFFFE, done at cycle 33, busy 1..33.
//  MUL 7*0xFFFFFFFD -> 0xFFFFFFEB at cycle 33; no NEG states entered.
//  MULH 0x80000000*0x80000000 -> 0x40000000 at cycle 35 (sa=sb=1, nr=0).
//  MULH 0xFFFFFFFF*1 -> 0xFFFFFFFF at 36; MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF at 36.
//  flush at cycle 10 -> busy 0 at 11, no done, result unchanged; start at 12 completes normally.
//  start pulsed while busy is ignored. rst_n low at cycle 20 -> all outputs 0 asynchronously.
//  Adder ports are 0 whenever the FSM is in IDLE/DONE.

Source files
------------

// File: rtl/shared_adder_mul_seq_pkg.sv
// Shared types for the RV32M multiply sequencer.
// Op encodings follow funct3[1:0] of MUL/MULH/MULHSU/MULHU.
package shared_adder_mul_seq_pkg;

    localparam int MUL_N     = 32;
    localparam int MUL_CNT_W = 6;

    typedef enum logic [1:0] {
        OP_MUL    = 2'b00,
        OP_MULH   = 2'b01,
        OP_MULHSU = 2'b10,
        OP_MULHU  = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_NEG_A,
        S_NEG_B,
        S_ITER,
        S_NEG_LO,
        S_NEG_HI,
        S_DONE
    } state_e;

endpackage

// File: rtl/shared_adder_mul_seq_if.sv
// EX-side request/response plus the shared adder port bundle.
// slave = sequencer, master = parent (EX stage + adder owner).
interface shared_adder_mul_seq_if #(
    parameter int N = 32
);
    logic         start;
    logic [1:0]   op;
    logic [N-1:0] rs1;
    logic [N-1:0] rs2;
    logic         flush;
    logic         busy;
    logic         done;
    logic [N-1:0] result;
    logic [N-1:0] add_a;
    logic [N-1:0] add_b;
    logic         add_cin;
    logic [N:0]   add_sum;

    modport slave (
        input  start, op, rs1, rs2, flush, add_sum,
        output busy, done, result, add_a, add_b, add_cin
    );

    modport master (
        output start, op, rs1, rs2, flush, add_sum,
        input  busy, done, result, add_a, add_b, add_cin
    );

endinterface

// File: rtl/shared_adder_mul_seq.sv
// Radix-2 shift-add RV32M multiplier sequencing an external N-bit adder.
// Signed ops multiply magnitudes, then negate the 2N-bit product.
module shared_adder_mul_seq
    import shared_adder_mul_seq_pkg::*;
#(
    parameter int N     = 32,
    parameter int CNT_W = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    shared_adder_mul_seq_if.slave bus
);

    state_e       r_state;
    state_e       w_state_nxt;
    op_e          r_op;
    op_e          w_op;
    logic [N-1:0] r_a;
    logic [N-1:0] r_hi;
    logic [N-1:0] r_lo;
    logic [N-1:0] r_result;
    logic [CNT_W-1:0] r_cnt;
    logic         r_sb;
    logic         r_nr;
    logic         r_c;
    logic         w_sa;
    logic         w_sb;
    logic [N-1:0] w_add_a;
    logic [N-1:0] w_add_b;
    logic         w_cin;
    logic [N:0]   w_sum;
    logic [N-1:0] w_sel;

    assign w_op  = op_e'(bus.op);
    assign w_sa  = bus.rs1[N-1] & (w_op == OP_MULH || w_op == OP_MULHSU);
    assign w_sb  = bus.rs2[N-1] & (w_op == OP_MULH);
    assign w_sum = bus.add_sum;
    assign w_sel = (r_op == OP_MUL) ? r_lo : r_hi;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:
                if (bus.start)
                    w_state_nxt = w_sa ? S_NEG_A :
                                  (w_sb ? S_NEG_B : S_ITER);
            S_NEG_A:  w_state_nxt = r_sb ? S_NEG_B : S_ITER;
            S_NEG_B:  w_state_nxt = S_ITER;
            S_ITER:
                if (r_cnt == '0)
                    w_state_nxt = r_nr ? S_NEG_LO : S_DONE;
            S_NEG_LO: w_state_nxt = S_NEG_HI;
            S_NEG_HI: w_state_nxt = S_DONE;
            S_DONE:   w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
        if (bus.flush)
            w_state_nxt = S_IDLE;
    end

    // Adder is released (all zero) outside NEG_*/ITER for other users.
    always_comb begin
        w_add_a = '0;
        w_add_b = '0;
        w_cin   = 1'b0;
        case (r_state)
            S_NEG_A: begin
                w_add_a = ~r_a;
                w_cin   = 1'b1;
            end
            S_NEG_B, S_NEG_LO: begin
                w_add_a = ~r_lo;
                w_cin   = 1'b1;
            end
            S_ITER: begin
                w_add_a = r_hi;
                w_add_b = r_lo[0] ? r_a : '0;
            end
            S_NEG_HI: begin
                w_add_a = ~r_hi;
                w_cin   = r_c;
            end
            default: ;
        endcase
    end

    assign bus.add_a   = w_add_a;
    assign bus.add_b   = w_add_b;
    assign bus.add_cin = w_cin;
    assign bus.busy    = (r_state != S_IDLE);
    assign bus.done    = (r_state == S_DONE) & ~bus.flush;
    assign bus.result  = bus.done ? w_sel : r_result;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_op     <= OP_MUL;
            r_a      <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_result <= '0;
            r_cnt    <= '0;
            r_sb     <= 1'b0;
            r_nr     <= 1'b0;
            r_c      <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                S_IDLE:
                    if (bus.start && !bus.flush) begin
                        r_op  <= w_op;
                        r_a   <= bus.rs1;
                        r_lo  <= bus.rs2;
                        r_hi  <= '0;
                        r_cnt <= CNT_W'(N - 1);
                        r_sb  <= w_sb;
                        r_nr  <= w_sa ^ w_sb;
                    end
                S_NEG_A: r_a  <= w_sum[N-1:0];
                S_NEG_B: r_lo <= w_sum[N-1:0];
                S_ITER: begin
                    r_hi  <= w_sum[N:1];
                    r_lo  <= {w_sum[0], r_lo[N-1:1]};
                    r_cnt <= r_cnt - 1'b1;
                end
                S_NEG_LO: begin
                    r_lo <= w_sum[N-1:0];
                    r_c  <= w_sum[N];
                end
                S_NEG_HI: r_hi <= w_sum[N-1:0];
                S_DONE:
                    if (!bus.flush)
                        r_result <= w_sel;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_shared_adder_mul_seq.sv
// Self-checking bench: the parent's adder is modelled here, results
// are checked against 64-bit arithmetic and the documented latency.
module tb_shared_adder_mul_seq;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;
    logic [31:0] last_res;

    shared_adder_mul_seq_if #(.N(32)) bus ();

    assign bus.add_sum = {1'b0, bus.add_a} + {1'b0, bus.add_b}
                       + {32'b0, bus.add_cin};

    shared_adder_mul_seq #(.N(32), .CNT_W(6)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ref_mul(input logic [1:0] op,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
        logic signed [63:0] x;
        logic signed [63:0] y;
        logic [63:0] p;
        x = (op == 2'd1 || op == 2'd2) ? {{32{a[31]}}, a} : {32'b0, a};
        y = (op == 2'd1) ? {{32{b[31]}}, b} : {32'b0, b};
        p = x * y;
        return (op == 2'd0) ? p[31:0] : p[63:32];
    endfunction

    function automatic int ref_lat(input logic [1:0] op,
                                   input logic [31:0] a,
                                   input logic [31:0] b);
        int sa;
        int sb;
        sa = (a[31] && (op == 2'd1 || op == 2'd2)) ? 1 : 0;
        sb = (b[31] && op == 2'd1) ? 1 : 0;
        return 33 + sa + sb + 2 * (sa ^ sb);
    endfunction

    task automatic do_op(input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, output logic [31:0] res,
                         output int lat, output bit busy_bad,
                         output bit adder_bad);
        int cyc;
        lat = -1;
        res = 'x;
        busy_bad = 0;
        adder_bad = 0;
        @(posedge clk); #1;
        bus.start = 1'b1;
        bus.op = op;
        bus.rs1 = a;
        bus.rs2 = b;
        @(negedge clk);
        if (bus.busy !== 1'b0) busy_bad = 1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.rs1 = $urandom;
        bus.rs2 = $urandom;
        cyc = 1;
        for (int k = 0; k < 100 && lat < 0; k++) begin
            @(negedge clk);
            if (bus.busy !== 1'b1) busy_bad = 1;
            if (bus.done === 1'b1) begin
                lat = cyc;
                res = bus.result;
                if (bus.add_a !== 0 || bus.add_b !== 0 || bus.add_cin !== 0)
                    adder_bad = 1;
            end else begin
                @(posedge clk); #1;
                cyc++;
            end
        end
    endtask

    task automatic check_op(input string nm, input logic [1:0] op,
                            input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] exp_res, input int exp_lat);
        logic [31:0] res;
        int lat;
        bit bb;
        bit ab;
        do_op(op, a, b, res, lat, bb, ab);
        n_tests++;
        if (res !== exp_res) begin
            n_fail++;
            $display("FAIL %s result op=%0d a=%h b=%h got %h want %h",
                     nm, op, a, b, res, exp_res);
        end
        n_tests++;
        if (lat !== exp_lat) begin
            n_fail++;
            $display("FAIL %s latency op=%0d a=%h b=%h got %0d want %0d",
                     nm, op, a, b, lat, exp_lat);
        end
        n_tests++;
        if (bb || ab) begin
            n_fail++;
            $display("FAIL %s busy/adder busy_bad=%0d adder_bad=%0d want 0/0",
                     nm, bb, ab);
        end
        last_res = exp_res;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.flush = 1'b0;
        bus.op = 2'd0;
        bus.rs1 = '0;
        bus.rs2 = '0;
        #2;
        n_tests++;
        if ({bus.busy, bus.done, bus.result, bus.add_a, bus.add_b,
             bus.add_cin} !== '0) begin
            n_fail++;
            $display("FAIL reset outputs got busy=%b done=%b res=%h a=%h b=%h cin=%b want 0",
                     bus.busy, bus.done, bus.result, bus.add_a,
                     bus.add_b, bus.add_cin);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_tests++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle busy=%b done=%b want 0 0",
                     bus.busy, bus.done);
        end
        last_res = '0;
    endtask

    logic [1:0]  d_op  [5] = '{2'd3, 2'd0, 2'd1, 2'd1, 2'd2};
    logic [31:0] d_a   [5] = '{32'hFFFFFFFF, 32'h7, 32'h80000000,
                               32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [31:0] d_b   [5] = '{32'hFFFFFFFF, 32'hFFFFFFFD, 32'h80000000,
                               32'h1, 32'hFFFFFFFF};
    logic [31:0] d_res [5] = '{32'hFFFFFFFE, 32'hFFFFFFEB, 32'h40000000,
                               32'hFFFFFFFF, 32'hFFFFFFFF};
    int          d_lat [5] = '{33, 33, 35, 36, 36};

    task automatic test_directed();
        for (int i = 0; i < 5; i++)
            check_op($sformatf("directed%0d", i), d_op[i], d_a[i],
                     d_b[i], d_res[i], d_lat[i]);
    endtask

    task automatic test_random();
        logic [31:0] edges [4] = '{32'h0, 32'h80000000, 32'hFFFFFFFF,
                                   32'h7FFFFFFF};
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        for (int i = 0; i < 40; i++) begin
            op = 2'($urandom_range(0, 3));
            a = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 3)]
                                            : $urandom;
            b = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 3)]
                                            : $urandom;
            check_op("random", op, a, b, ref_mul(op, a, b),
                     ref_lat(op, a, b));
        end
    endtask

    task automatic test_flush();
        bit seen_done;
        seen_done = 0;
        @(posedge clk); #1;
        bus.start = 1'b1;
        bus.op = 2'd3;
        bus.rs1 = 32'h12345678;
        bus.rs2 = 32'h9ABCDEF0;
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int c = 1; c < 10; c++) begin
            @(negedge clk);
            if (bus.done === 1'b1) seen_done = 1;
            @(posedge clk); #1;
        end
        bus.flush = 1'b1;
        @(negedge clk);
        if (bus.done === 1'b1) seen_done = 1;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        @(negedge clk);
        n_tests++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || seen_done) begin
            n_fail++;
            $display("FAIL flush_idle busy=%b done=%b seen_done=%0d want 0 0 0",
                     bus.busy, bus.done, seen_done);
        end
        n_tests++;
        if (bus.result !== last_res) begin
            n_fail++;
            $display("FAIL flush_result got %h want %h", bus.result, last_res);
        end
        check_op("after_flush", 2'd1, 32'hDEADBEEF, 32'h00C0FFEE,
                 ref_mul(2'd1, 32'hDEADBEEF, 32'h00C0FFEE),
                 ref_lat(2'd1, 32'hDEADBEEF, 32'h00C0FFEE));
    endtask

    task automatic test_busy_start();
        int cyc;
        int lat;
        logic [31:0] res;
        lat = -1;
        res = 'x;
        @(posedge clk); #1;
        bus.start = 1'b1;
        bus.op = 2'd2;
        bus.rs1 = 32'h80000001;
        bus.rs2 = 32'h00000003;
        @(posedge clk); #1;
        bus.start = 1'b0;
        cyc = 1;
        for (int k = 0; k < 100 && lat < 0; k++) begin
            bus.start = (cyc == 5);
            if (cyc == 5) begin
                bus.op = 2'd3;
                bus.rs1 = 32'hFFFFFFFF;
                bus.rs2 = 32'hFFFFFFFF;
            end
            @(negedge clk);
            if (bus.done === 1'b1) begin
                lat = cyc;
                res = bus.result;
            end else begin
                @(posedge clk); #1;
                cyc++;
            end
        end
        bus.start = 1'b0;
        n_tests++;
        if (res !== ref_mul(2'd2, 32'h80000001, 32'h3) ||
            lat !== ref_lat(2'd2, 32'h80000001, 32'h3)) begin
            n_fail++;
            $display("FAIL busy_start got res=%h lat=%0d want res=%h lat=%0d",
                     res, lat, ref_mul(2'd2, 32'h80000001, 32'h3),
                     ref_lat(2'd2, 32'h80000001, 32'h3));
        end
        @(posedge clk); #1;
        @(negedge clk);
        n_tests++;
        if (bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_start_queued busy=%b want 0", bus.busy);
        end
        last_res = ref_mul(2'd2, 32'h80000001, 32'h3);
    endtask

    task automatic test_back_to_back();
        logic [31:0] a;
        logic [31:0] b;
        for (int i = 0; i < 4; i++) begin
            a = $urandom;
            b = $urandom;
            check_op("b2b", 2'(i), a, b, ref_mul(2'(i), a, b),
                     ref_lat(2'(i), a, b));
        end
    endtask

    task automatic test_reset_mid();
        @(posedge clk); #1;
        bus.start = 1'b1;
        bus.op = 2'd1;
        bus.rs1 = 32'hF0000000;
        bus.rs2 = 32'h00000011;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (19) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({bus.busy, bus.done, bus.result, bus.add_a, bus.add_b,
             bus.add_cin} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid got busy=%b done=%b res=%h a=%h b=%h cin=%b want 0",
                     bus.busy, bus.done, bus.result, bus.add_a,
                     bus.add_b, bus.add_cin);
        end
        @(negedge clk);
        rst_n = 1'b1;
        last_res = '0;
        check_op("after_reset", 2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF,
                 32'h00000001, 33);
    endtask

    initial begin
        n_tests = 0;
        n_fail = 0;
        test_reset();
        test_directed();
        test_random();
        test_flush();
        test_busy_start();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
